// File: rtl/fir_band_sequencer_if.sv
// Handshake and strobe bundle between the FIR band sequencer and the datapath it controls.
// TW/BW must match clog2(TAPS)/clog2(BANDS) of the attached sequencer.
interface fir_band_sequencer_if #(
    parameter int unsigned TW = 3,
    parameter int unsigned BW = 2
);
    logic          sample_valid;
    logic          sample_ready;
    logic          ld_d;
    logic          acc_clr;
    logic          mac_en;
    logic [TW-1:0] tap_sel;
    logic [BW-1:0] band_sel;
    logic          result_valid;
    logic          result_ready;
    logic          frame_done;
    logic          busy;

    modport master (
        input  sample_valid,
        input  result_ready,
        output sample_ready,
        output ld_d,
        output acc_clr,
        output mac_en,
        output tap_sel,
        output band_sel,
        output result_valid,
        output frame_done,
        output busy
    );

    modport slave (
        output sample_valid,
        output result_ready,
        input  sample_ready,
        input  ld_d,
        input  acc_clr,
        input  mac_en,
        input  tap_sel,
        input  band_sel,
        input  result_valid,
        input  frame_done,
        input  busy
    );
endinterface

// File: rtl/fir_band_sequencer.sv
// Frame sequencer for the banded FIR datapath: shifts one sample into the delay line, then
// walks every tap of every band through the shared MAC and hands each band result downstream.
module fir_band_sequencer #(
    parameter int unsigned TAPS    = 8,
    parameter int unsigned BANDS   = 4,
    parameter int unsigned MAC_LAT = 3
) (
    input logic            clk,
    input logic            clr,
    fir_band_sequencer_if.master bus
);
    localparam int unsigned TW = $clog2(TAPS);
    localparam int unsigned BW = $clog2(BANDS);
    localparam int unsigned LW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

    typedef enum logic [2:0] {StIdle, StShift, StMac, StDrain, StStore} state_e;

    state_e        state_q, state_d;
    logic [TW-1:0] tap_q, tap_d;
    logic [BW-1:0] band_q, band_d;
    logic [LW-1:0] lat_q, lat_d;

    logic ld_q, mac_q, acc_clr_q, rv_q, busy_q, ready_q;
    logic last_tap, last_band, last_lat, accept;

    assign last_tap  = (tap_q == TW'(TAPS - 1));
    assign last_band = (band_q == BW'(BANDS - 1));
    assign last_lat  = ((int'(lat_q) + 1) >= int'(MAC_LAT));
    assign accept    = (state_q == StStore) && bus.result_ready;

    always_comb begin
        state_d = state_q;
        tap_d   = tap_q;
        band_d  = band_q;
        lat_d   = lat_q;
        unique case (state_q)
            StIdle: begin
                if (bus.sample_valid) state_d = StShift;
            end
            StShift: begin
                state_d = StMac;
            end
            StMac: begin
                if (last_tap) begin
                    tap_d   = '0;
                    lat_d   = '0;
                    // With no MAC pipeline the accumulator is final right after the last tap.
                    state_d = (MAC_LAT == 0) ? StStore : StDrain;
                end else begin
                    tap_d = tap_q + TW'(1);
                end
            end
            StDrain: begin
                if (last_lat) state_d = StStore;
                else          lat_d   = lat_q + LW'(1);
            end
            StStore: begin
                if (bus.result_ready) begin
                    if (last_band) begin
                        band_d  = '0;
                        state_d = StIdle;
                    end else begin
                        band_d  = band_q + BW'(1);
                        state_d = StMac;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Strobes are decoded from the next state so they are flop outputs aligned with the state.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q   <= StIdle;
            tap_q     <= '0;
            band_q    <= '0;
            lat_q     <= '0;
            ld_q      <= 1'b0;
            mac_q     <= 1'b0;
            acc_clr_q <= 1'b0;
            rv_q      <= 1'b0;
            busy_q    <= 1'b0;
            ready_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            tap_q     <= tap_d;
            band_q    <= band_d;
            lat_q     <= lat_d;
            ld_q      <= (state_d == StShift);
            mac_q     <= (state_d == StMac);
            acc_clr_q <= (state_d == StMac) && (tap_d == '0);
            rv_q      <= (state_d == StStore);
            busy_q    <= (state_d != StIdle);
            ready_q   <= (state_d == StIdle);
        end
    end

    assign bus.sample_ready = ready_q;
    assign bus.ld_d         = ld_q;
    assign bus.acc_clr      = acc_clr_q;
    assign bus.mac_en       = mac_q;
    assign bus.tap_sel      = tap_q;
    assign bus.band_sel     = band_q;
    assign bus.result_valid = rv_q;
    assign bus.busy         = busy_q;
    assign bus.frame_done   = accept && last_band;
endmodule

// File: tb/tb_fir_band_sequencer.sv
// Scoreboard bench for fir_band_sequencer: default and minimal configurations run side by side
// against a frame-position reference model.
module tb_fir_band_sequencer;
    typedef struct packed {
        logic       sr, busy, ld, mac, acc, rv, fd;
        logic [7:0] tap, band;
    } obs_t;

    typedef struct {
        bit active;
        int pos;   // 1 = shift slot, 2.. = band slots; frozen while a result is stalled
    } mst_t;

    logic clk = 1'b0;
    logic clr = 1'b0;
    logic sv  = 1'b0;
    logic rr  = 1'b0;

    int   checks   = 0;
    int   failures = 0;
    mst_t m [2];
    obs_t eq0 [$];
    obs_t eq1 [$];
    int   rq0 [$];
    int   rq1 [$];
    int   blen [2];
    int   last_len [2];
    obs_t obs0, obs1;

    always #5 clk = ~clk;

    fir_band_sequencer_if #(.TW(3), .BW(2)) if0 ();
    fir_band_sequencer_if #(.TW(1), .BW(1)) if1 ();

    assign if0.sample_valid = sv;
    assign if0.result_ready = rr;
    assign if1.sample_valid = sv;
    assign if1.result_ready = rr;

    fir_band_sequencer #(.TAPS(8), .BANDS(4), .MAC_LAT(3)) dut0 (.clk(clk), .clr(clr), .bus(if0));
    fir_band_sequencer #(.TAPS(2), .BANDS(2), .MAC_LAT(0)) dut1 (.clk(clk), .clr(clr), .bus(if1));

    assign obs0 = '{sr: if0.sample_ready, busy: if0.busy, ld: if0.ld_d, mac: if0.mac_en,
                    acc: if0.acc_clr, rv: if0.result_valid, fd: if0.frame_done,
                    tap: 8'(if0.tap_sel), band: 8'(if0.band_sel)};
    assign obs1 = '{sr: if1.sample_ready, busy: if1.busy, ld: if1.ld_d, mac: if1.mac_en,
                    acc: if1.acc_clr, rv: if1.result_valid, fd: if1.frame_done,
                    tap: 8'(if1.tap_sel), band: 8'(if1.band_sel)};

    function automatic int p_taps(input int d);  return (d == 0) ? 8 : 2; endfunction
    function automatic int p_bands(input int d); return (d == 0) ? 4 : 2; endfunction
    function automatic int p_lat(input int d);   return (d == 0) ? 3 : 0; endfunction
    function automatic int p_slot(input int d);  return p_taps(d) + p_lat(d) + 1; endfunction

    // 0 idle, 1 shift, 2 tap, 3 waiting on MAC pipeline, 4 presenting result
    function automatic int kind(input int d, input mst_t s);
        int r;
        if (!s.active) return 0;
        if (s.pos == 1) return 1;
        r = (s.pos - 2) % p_slot(d);
        if (r < p_taps(d)) return 2;
        if (r < p_taps(d) + p_lat(d)) return 3;
        return 4;
    endfunction

    function automatic int mband(input int d, input mst_t s);
        return (s.active && s.pos >= 2) ? (s.pos - 2) / p_slot(d) : 0;
    endfunction

    function automatic int mtap(input int d, input mst_t s);
        return (kind(d, s) == 2) ? (s.pos - 2) % p_slot(d) : 0;
    endfunction

    function automatic obs_t expect_out(input int d, input mst_t s, input bit r);
        obs_t e;
        int   k;
        k      = kind(d, s);
        e.sr   = (k == 0);
        e.busy = (k != 0);
        e.ld   = (k == 1);
        e.mac  = (k == 2);
        e.acc  = (k == 2) && (mtap(d, s) == 0);
        e.rv   = (k == 4);
        e.fd   = (k == 4) && r && (mband(d, s) == p_bands(d) - 1);
        e.tap  = 8'(mtap(d, s));
        e.band = 8'(mband(d, s));
        return e;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_obs(input int d, input obs_t o, input obs_t e);
        chk($sformatf("d%0d_sample_ready", d), int'(o.sr), int'(e.sr));
        chk($sformatf("d%0d_busy", d), int'(o.busy), int'(e.busy));
        chk($sformatf("d%0d_ld_d", d), int'(o.ld), int'(e.ld));
        chk($sformatf("d%0d_mac_en", d), int'(o.mac), int'(e.mac));
        chk($sformatf("d%0d_acc_clr", d), int'(o.acc), int'(e.acc));
        chk($sformatf("d%0d_result_valid", d), int'(o.rv), int'(e.rv));
        chk($sformatf("d%0d_frame_done", d), int'(o.fd), int'(e.fd));
        chk($sformatf("d%0d_tap_sel", d), int'(o.tap), int'(e.tap));
        chk($sformatf("d%0d_band_sel", d), int'(o.band), int'(e.band));
    endtask

    // Advance the model across a rising edge using the inputs held over that edge.
    task automatic tick();
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            int k;
            k = kind(d, m[d]);
            if (!clr) begin
                m[d].active = 1'b0;
            end else if (k == 0) begin
                if (sv) begin
                    m[d].active = 1'b1;
                    m[d].pos    = 1;
                    for (int b = 0; b < p_bands(d); b++) begin
                        if (d == 0) rq0.push_back(b * 2 + int'(b == p_bands(d) - 1));
                        else        rq1.push_back(b * 2 + int'(b == p_bands(d) - 1));
                    end
                end
            end else if (k == 4) begin
                if (rr) begin
                    if (mband(d, m[d]) == p_bands(d) - 1) m[d].active = 1'b0;
                    else                                  m[d].pos++;
                end
            end else begin
                m[d].pos++;
            end
        end
        #1;
    endtask

    task automatic commit(input bit nsv, input bit nrr, input bit ncl);
        sv  = nsv;
        rr  = nrr;
        clr = ncl;
        if (!ncl) begin
            m[0].active = 1'b0;
            m[1].active = 1'b0;
            rq0.delete();
            rq1.delete();
        end
        eq0.push_back(expect_out(0, m[0], nrr));
        eq1.push_back(expect_out(1, m[1], nrr));
    endtask

    task automatic idle_run(input int n);
        repeat (n) begin
            tick();
            commit(1'b0, 1'b1, 1'b1);
        end
    endtask

    // Monitor: per-cycle strobe comparison plus result-transaction scoreboard.
    initial begin
        blen = '{0, 0};
        last_len = '{0, 0};
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                obs_t o, e;
                int   x;
                o = (d == 0) ? obs0 : obs1;
                if (d == 0 && eq0.size() > 0) begin e = eq0.pop_front(); chk_obs(d, o, e); end
                if (d == 1 && eq1.size() > 0) begin e = eq1.pop_front(); chk_obs(d, o, e); end
                if (o.rv && rr) begin
                    if ((d == 0 && rq0.size() == 0) || (d == 1 && rq1.size() == 0)) begin
                        chk($sformatf("d%0d_result_expected", d), 0, 1);
                    end else begin
                        x = (d == 0) ? rq0.pop_front() : rq1.pop_front();
                        chk($sformatf("d%0d_result_band", d), int'(o.band), x / 2);
                        chk($sformatf("d%0d_result_frame_done", d), int'(o.fd), x % 2);
                    end
                end
                if (o.busy) begin
                    blen[d]++;
                end else if (blen[d] > 0) begin
                    last_len[d] = blen[d];
                    blen[d]     = 0;
                end
            end
        end
    end

    initial begin
        int  stalled;
        bit  found;
        bit  nrr;
        m[0] = '{active: 1'b0, pos: 0};
        m[1] = '{active: 1'b0, pos: 0};

        // Reset held, then a quiet idle stretch.
        repeat (3) begin
            tick();
            commit(1'b0, 1'b0, 1'b0);
        end
        idle_run(20);

        // Single frame, result_ready tied high.
        tick();
        commit(1'b1, 1'b1, 1'b1);
        idle_run(55);
        chk("d0_len_single", last_len[0], 49);
        chk("d1_len_single", last_len[1], 7);

        // Five stall cycles while band 1 is presented.
        stalled = 0;
        tick();
        commit(1'b1, 1'b1, 1'b1);
        repeat (62) begin
            tick();
            nrr = 1'b1;
            if (kind(0, m[0]) == 4 && mband(0, m[0]) == 1 && stalled < 5) begin
                nrr = 1'b0;
                stalled++;
            end
            commit(1'b0, nrr, 1'b1);
        end
        chk("d0_len_stalled", last_len[0], 54);

        // A sample pulse mid-frame must be ignored.
        tick();
        commit(1'b1, 1'b1, 1'b1);
        for (int n = 1; n < 56; n++) begin
            tick();
            commit(n == 20, 1'b1, 1'b1);
        end
        chk("d0_len_ignored_sample", last_len[0], 49);

        // Reset asserted during band 2 tap 5, then a clean frame.
        tick();
        commit(1'b1, 1'b1, 1'b1);
        found = 1'b0;
        for (int n = 0; n < 100 && !found; n++) begin
            tick();
            if (kind(0, m[0]) == 2 && mband(0, m[0]) == 2 && mtap(0, m[0]) == 5) begin
                found = 1'b1;
                commit(1'b0, 1'b1, 1'b0);
            end else begin
                commit(1'b0, 1'b1, 1'b1);
            end
        end
        chk("reached_band2_tap5", int'(found), 1);
        tick();
        commit(1'b0, 1'b1, 1'b0);
        idle_run(3);
        tick();
        commit(1'b1, 1'b1, 1'b1);
        idle_run(55);
        chk("d0_len_after_reset", last_len[0], 49);

        // Randomised traffic: bursty samples, random backpressure, rare resets.
        repeat (3000) begin
            tick();
            commit($urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0,
                   $urandom_range(0, 299) != 0);
        end
        idle_run(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fir_band_sequencer.md
# fir_band_sequencer

Control sequencer for the 4-band 10-bit floating-point FIR datapath. It accepts one input sample per frame and pulses the shared load enable of the delay-element chain to shift the sample in. It then walks the tap index through every tap for each band in turn, driving the shared MAC and coefficient-select lines. It presents each band result through a valid/ready handshake before returning to idle.

## Interface
Parameters:
- TAPS, 8, taps per band; must be 2 or more; tap_sel width is TW = clog2(TAPS)
- BANDS, 4, number of bands; band_sel width is BW = clog2(BANDS), and BW must be 1 or more
- MAC_LAT, 3, pipeline latency of the floating-point multiply-accumulate; may be 0 or more

Ports:
- clk  in  1  clock; all state updates on the rising edge
- clr  in  1  reset, asynchronous, active-low
- sample_valid  in  1  a new input sample is present at the head of the delay chain
- sample_ready  out  1  the sequencer is in IDLE and will accept a sample
- ld_d  out  1  load enable to every delay element (the delay-line shift)
- acc_clr  out  1  clears the MAC accumulator; coincides with tap 0 of each band
- mac_en  out  1  MAC accumulates the product for tap_sel/band_sel this cycle
- tap_sel  out  TW  tap index, used as the delay-output mux select and the coefficient ROM address low bits
- band_sel  out  BW  band index, used as the coefficient ROM address high bits and the result tag
- result_valid  out  1  the accumulator holds the finished result for band_sel
- result_ready  in  1  downstream has taken the band result
- frame_done  out  1  one-cycle pulse when the last band's result is accepted
- busy  out  1  high in every state except IDLE

## Operation
- Moore FSM. States: IDLE, SHIFT, MAC, DRAIN, STORE. Counters: tap_cnt (TW bits), lat_cnt, band_cnt (BW bits).
- IDLE
  - sample_ready=1.
  - On sample_valid=1, go to SHIFT. tap_cnt and band_cnt are already 0.
- SHIFT
  - ld_d=1 for exactly one cycle.
  - Go to MAC.
- MAC
  - mac_en=1 and tap_sel=tap_cnt; acc_clr=1 only while tap_cnt=0.
  - tap_cnt increments each cycle.
  - At tap_cnt=TAPS-1: tap_cnt wraps to 0, lat_cnt loads 0, go to DRAIN. If MAC_LAT=0, go straight to STORE.
- DRAIN
  - All strobes low.
  - Stay MAC_LAT cycles, then go to STORE.
- STORE
  - result_valid=1 and band_sel=band_cnt; hold until result_ready=1.
  - On acceptance with band_cnt<BANDS-1: band_cnt increments, go to MAC.
  - On acceptance with band_cnt=BANDS-1: band_cnt goes to 0, frame_done=1 for that cycle (combinational with the accepting handshake), go to IDLE.
- band_sel follows band_cnt in every state; tap_sel follows tap_cnt in every state.
- sample_valid outside IDLE is ignored. It is not queued.
- ld_d is never high outside SHIFT. The delay line must not move while any band is being computed.
- result_ready outside STORE is ignored.

## Timing
- Reset: clr=0 forces IDLE, all counters to 0, ld_d=0, acc_clr=0, mac_en=0, tap_sel=0, band_sel=0, result_valid=0, frame_done=0, busy=0, sample_ready=1. This applies immediately, including mid-frame. A partly computed frame is abandoned and no result_valid follows.
- Accept at edge k (IDLE, sample_valid=1) gives:
  - ld_d in cycle k+1;
  - band 0 taps in cycles k+2 to k+1+TAPS;
  - result_valid from cycle k+2+TAPS+MAC_LAT.
- Zero-stall frame length from accept to return to IDLE is 1 + BANDS*(TAPS+MAC_LAT+1) cycles. With defaults this is 49, so sample_ready is back at k+50.
- A result_ready stall adds exactly one cycle per stalled cycle. Outputs stay constant during the stall.
- Back-to-back frames: sample_valid held high re-accepts on the first IDLE cycle. There are no dead cycles beyond IDLE itself.

## Test plan
- Reset then idle: clr low for 3 cycles, then high, sample_valid=0 -> sample_ready=1, busy=0, all strobes 0 for 20 cycles.
- Single frame, defaults, result_ready tied 1:
  - ld_d high exactly once, 1 cycle after accept;
  - mac_en high for 4 runs of 8 cycles with tap_sel 0..7;
  - acc_clr coincides with tap 0 of each run;
  - result_valid at band_sel 0,1,2,3;
  - frame_done coincides with band 3;
  - sample_ready returns 50 cycles after accept.
- Backpressure: result_ready=0 for 5 cycles at band 1 -> result_valid and band_sel=1 held, no mac_en/ld_d, frame length 54.
- Ignored sample: pulse sample_valid mid-frame (cycle 20) -> no extra ld_d, frame timing unchanged.
- Reset mid-operation: clr low during MAC of band 2, tap 5 -> outputs take reset values immediately, IDLE after release, next sample starts at band 0 tap 0.
- Parameter sweep: TAPS=2, BANDS=2, MAC_LAT=0 -> DRAIN skipped, frame length 7 cycles, tap_sel toggles 0,1 per band.
